// File: rtl/core_bus_requester.sv
// rtl/core_bus_requester.sv - core-side initiator for the shared snooping bus
//
// Sits between the L1 cache controller and the bus controller. It accepts one
// miss/upgrade request, arbitrates for the bus, drives a single address phase,
// collects the peer-cache or L2 response and hands it back to L1 with a
// one-cycle strobe. The core is stalled for the whole transaction.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   miss_*              request from L1 (op, address, write data), sampled in IDLE
//   opcode_in           RISC-V opcode of the instruction that caused the miss
//   stall_out           core pipeline stall
//   resp_*              response to L1: valid strobe, data, source, timeout error
//   req_core, grant     request/grant handshake with the arbiter
//   bus_*_out           address-phase outputs, nonzero only in ADDR
//   opcode_out          opcode driven to the bus in ADDR
//   flush_out           one-cycle abort pulse to the bus controller
//   bus_data_in         response data from the bus controller
//   cache_hit_in        peer-cache snoop hit qualifier for bus_data_in
//   l2_valid_in         L2 response qualifier for bus_data_in

module core_bus_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_req,
  input  logic [1:0]        miss_op,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [DATA_W-1:0] miss_wdata,
  input  logic [6:0]        opcode_in,
  output logic              stall_out,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_src,
  output logic              resp_err,
  output logic              req_core,
  input  logic              grant,
  output logic [1:0]        bus_operation_out,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic [DATA_W-1:0] bus_data_out,
  output logic [6:0]        opcode_out,
  output logic              flush_out,
  input  logic [DATA_W-1:0] bus_data_in,
  input  logic              cache_hit_in,
  input  logic              l2_valid_in
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_UPGR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [6:0]         opcode_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               req_core_q;
  logic [1:0]         bus_op_q;
  logic [ADDR_W-1:0]  bus_addr_q;
  logic [DATA_W-1:0]  bus_data_q;
  logic [6:0]         opcode_out_q;
  logic               flush_q;
  logic               resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic               resp_src_q;
  logic               resp_err_q;

  logic accept;
  logic resp_any;
  logic cnt_last;
  logic abort_d;
  logic timeout_d;

  assign accept   = miss_req && (miss_op != OP_NONE);
  assign resp_any = cache_hit_in || l2_valid_in;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state logic. abort_d covers both a lost grant (retry) and a timeout;
  // a response in the same cycle always takes precedence over either.
  always_comb begin
    state_d   = state_q;
    abort_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ:   if (grant) state_d = S_ADDR;
      S_ADDR:  state_d = (op_q == OP_UPGR) ? S_DONE : S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (resp_any) begin
          state_d = S_DONE;
        end else if (!grant) begin
          state_d = S_REQ;
          abort_d = 1'b1;
        end else if (cnt_last) begin
          state_d   = S_DONE;
          abort_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with
  // the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      opcode_q     <= '0;
      cnt_q        <= '0;
      req_core_q   <= 1'b0;
      bus_op_q     <= OP_NONE;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      opcode_out_q <= '0;
      flush_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_src_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && accept) begin
        op_q     <= miss_op;
        addr_q   <= miss_addr;
        wdata_q  <= miss_wdata;
        opcode_q <= opcode_in;
      end

      cnt_q <= (state_q == S_WAIT_RESP && state_d == S_WAIT_RESP) ?
               cnt_q + CNT_W'(1) : '0;

      req_core_q <= (state_d == S_REQ) || (state_d == S_ADDR) ||
                    (state_d == S_WAIT_RESP);

      if (state_d == S_ADDR) begin
        bus_op_q     <= op_q;
        bus_addr_q   <= addr_q;
        bus_data_q   <= (op_q == OP_RDX) ? wdata_q : '0;
        opcode_out_q <= opcode_q;
      end else begin
        bus_op_q     <= OP_NONE;
        bus_addr_q   <= '0;
        bus_data_q   <= '0;
        opcode_out_q <= '0;
      end

      flush_q      <= abort_d;
      resp_valid_q <= (state_d == S_DONE);
      // Data is only captured on a real response; UPGR and timeout return 0.
      resp_data_q  <= (state_q == S_WAIT_RESP && resp_any) ? bus_data_in : '0;
      resp_src_q   <= (state_q == S_WAIT_RESP) && cache_hit_in;
      resp_err_q   <= timeout_d;
    end
  end

  // Stall in the request cycle itself so the core never issues past a miss.
  assign stall_out = (state_q == S_IDLE) ? accept : 1'b1;

  assign req_core          = req_core_q;
  assign bus_operation_out = bus_op_q;
  assign bus_address_out   = bus_addr_q;
  assign bus_data_out      = bus_data_q;
  assign opcode_out        = opcode_out_q;
  assign flush_out         = flush_q;
  assign resp_valid        = resp_valid_q;
  assign resp_data         = resp_data_q;
  assign resp_src          = resp_src_q;
  assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_core_bus_requester.sv
// tb/tb_core_bus_requester.sv - directed self-checking bench for core_bus_requester

module tb_core_bus_requester;

  logic        clk;
  logic        reset;
  logic        miss_req;
  logic [1:0]  miss_op;
  logic [31:0] miss_addr;
  logic [31:0] miss_wdata;
  logic [6:0]  opcode_in;
  logic        stall_out;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_src;
  logic        resp_err;
  logic        req_core;
  logic        grant;
  logic [1:0]  bus_operation_out;
  logic [31:0] bus_address_out;
  logic [31:0] bus_data_out;
  logic [6:0]  opcode_out;
  logic        flush_out;
  logic [31:0] bus_data_in;
  logic        cache_hit_in;
  logic        l2_valid_in;

  int n_cmp;
  int n_bad;

  int          req_hi, addr_cnt, rv_cnt, rv_cyc, fl_cnt, fl_cyc;
  logic [1:0]  seen_op;
  logic [31:0] seen_addr, first_addr, seen_data, rdata;
  logic [6:0]  seen_opc;
  logic        rsrc, rerr, st_x;

  core_bus_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_op(miss_op), .miss_addr(miss_addr),
    .miss_wdata(miss_wdata), .opcode_in(opcode_in),
    .stall_out(stall_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_src(resp_src), .resp_err(resp_err), .req_core(req_core), .grant(grant),
    .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .opcode_out(opcode_out), .flush_out(flush_out),
    .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in), .l2_valid_in(l2_valid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_tally();
    req_hi = 0; addr_cnt = 0; rv_cnt = 0; rv_cyc = -1; fl_cnt = 0; fl_cyc = -1;
    seen_op = 2'b00; seen_addr = '0; first_addr = '0; seen_data = '0;
    seen_opc = '0; rdata = '0; rsrc = 1'b0; rerr = 1'b0;
  endtask

  task automatic sample(input int c);
    if (req_core) req_hi++;
    if (bus_operation_out != 2'b00) begin
      addr_cnt++;
      seen_op = bus_operation_out; seen_addr = bus_address_out;
      seen_data = bus_data_out; seen_opc = opcode_out;
      if (addr_cnt == 1) first_addr = bus_address_out;
    end
    if (resp_valid) begin
      rv_cnt++; rv_cyc = c; rdata = resp_data; rsrc = resp_src; rerr = resp_err;
    end
    if (flush_out) begin fl_cnt++; fl_cyc = c; end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [6:0] opc);
    miss_req = 1'b1; miss_op = op; miss_addr = a; miss_wdata = wd; opcode_in = opc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (req_core !== 1'b0) begin n_bad++; $display("FAIL rst_req_core got %b want 0", req_core); end
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", stall_out); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data got %h want 0", resp_data); end
    n_cmp++; if ({resp_src, resp_err, flush_out} !== 3'b000) begin n_bad++; $display("FAIL rst_src_err_flush got %b want 000", {resp_src, resp_err, flush_out}); end
    n_cmp++; if (bus_operation_out !== 2'b00) begin n_bad++; $display("FAIL rst_bus_op got %b want 00", bus_operation_out); end
    n_cmp++; if (bus_address_out !== 32'h0) begin n_bad++; $display("FAIL rst_bus_addr got %h want 0", bus_address_out); end
    n_cmp++; if (bus_data_out !== 32'h0) begin n_bad++; $display("FAIL rst_bus_data got %h want 0", bus_data_out); end
    n_cmp++; if (opcode_out !== 7'h0) begin n_bad++; $display("FAIL rst_opcode_out got %h want 0", opcode_out); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_core !== 1'b0) begin n_bad++; $display("FAIL rst_release_req_core got %b want 0", req_core); end
  endtask

  task automatic test_rd();
    clear_tally();
    issue(2'b01, 32'h0000_0040, 32'h0, 7'h03);
    #1;
    n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL rd_stall_issue got %b want 1", stall_out); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      sample(c);
      if (c == 8) st_x = stall_out;
      miss_req = 1'b0;
      grant = (c >= 3 && c <= 6);
      l2_valid_in = (c == 6);
      bus_data_in = (c == 6) ? 32'hDEAD_BEEF : 32'h0;
    end
    n_cmp++; if (req_hi != 6) begin n_bad++; $display("FAIL rd_req_core_cycles got %0d want 6", req_hi); end
    n_cmp++; if (addr_cnt != 1) begin n_bad++; $display("FAIL rd_addr_cycles got %0d want 1", addr_cnt); end
    n_cmp++; if (seen_op !== 2'b01) begin n_bad++; $display("FAIL rd_bus_op got %b want 01", seen_op); end
    n_cmp++; if (seen_addr !== 32'h40) begin n_bad++; $display("FAIL rd_bus_addr got %h want 00000040", seen_addr); end
    n_cmp++; if (seen_opc !== 7'h03) begin n_bad++; $display("FAIL rd_opcode_out got %h want 03", seen_opc); end
    n_cmp++; if (seen_data !== 32'h0) begin n_bad++; $display("FAIL rd_bus_data got %h want 0", seen_data); end
    n_cmp++; if (rv_cnt != 1 || rv_cyc != 7) begin n_bad++; $display("FAIL rd_resp_valid got cnt %0d cyc %0d want cnt 1 cyc 7", rv_cnt, rv_cyc); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_resp_data got %h want deadbeef", rdata); end
    n_cmp++; if ({rsrc, rerr} !== 2'b00) begin n_bad++; $display("FAIL rd_src_err got %b want 00", {rsrc, rerr}); end
    n_cmp++; if (fl_cnt != 0) begin n_bad++; $display("FAIL rd_flush got %0d want 0", fl_cnt); end
    n_cmp++; if (st_x !== 1'b0) begin n_bad++; $display("FAIL rd_stall_idle got %b want 0", st_x); end
    l2_valid_in = 1'b0;
  endtask

  task automatic test_rdx();
    clear_tally();
    issue(2'b10, 32'h0000_0080, 32'h0000_1234, 7'h23);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      grant = (c <= 3);
      cache_hit_in = (c == 3);
      l2_valid_in = (c == 3);
      bus_data_in = (c == 3) ? 32'h0000_CAFE : 32'h0;
    end
    n_cmp++; if (seen_data !== 32'h1234) begin n_bad++; $display("FAIL rdx_bus_data got %h want 00001234", seen_data); end
    n_cmp++; if (seen_op !== 2'b10 || seen_addr !== 32'h80) begin n_bad++; $display("FAIL rdx_op_addr got %b/%h want 10/00000080", seen_op, seen_addr); end
    n_cmp++; if (rv_cnt != 1 || rv_cyc != 4) begin n_bad++; $display("FAIL rdx_resp_valid got cnt %0d cyc %0d want cnt 1 cyc 4", rv_cnt, rv_cyc); end
    n_cmp++; if (rdata !== 32'hCAFE) begin n_bad++; $display("FAIL rdx_resp_data got %h want 0000cafe", rdata); end
    n_cmp++; if (rsrc !== 1'b1) begin n_bad++; $display("FAIL rdx_resp_src got %b want 1", rsrc); end
    n_cmp++; if (req_hi != 3) begin n_bad++; $display("FAIL rdx_req_core_cycles got %0d want 3", req_hi); end
    cache_hit_in = 1'b0; l2_valid_in = 1'b0;
  endtask

  task automatic test_upgr();
    clear_tally();
    issue(2'b11, 32'h0000_0100, 32'h0000_5555, 7'h2F);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      grant = (c <= 2);
      bus_data_in = 32'h1111_2222;
    end
    n_cmp++; if (rv_cnt != 1 || rv_cyc != 3) begin n_bad++; $display("FAIL upgr_resp_valid got cnt %0d cyc %0d want cnt 1 cyc 3", rv_cnt, rv_cyc); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL upgr_resp_data got %h want 0", rdata); end
    n_cmp++; if (seen_op !== 2'b11 || seen_data !== 32'h0) begin n_bad++; $display("FAIL upgr_op_data got %b/%h want 11/0", seen_op, seen_data); end
    n_cmp++; if (req_hi != 2) begin n_bad++; $display("FAIL upgr_req_core_cycles got %0d want 2", req_hi); end
    bus_data_in = 32'h0;
  endtask

  task automatic test_timeout();
    clear_tally();
    issue(2'b01, 32'h0000_03C0, 32'h0, 7'h03);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      grant = (c <= 18);
      bus_data_in = 32'hFFFF_FFFF;
    end
    n_cmp++; if (fl_cnt != 1 || fl_cyc != 19) begin n_bad++; $display("FAIL to_flush got cnt %0d cyc %0d want cnt 1 cyc 19", fl_cnt, fl_cyc); end
    n_cmp++; if (rv_cnt != 1 || rv_cyc != 19) begin n_bad++; $display("FAIL to_resp_valid got cnt %0d cyc %0d want cnt 1 cyc 19", rv_cnt, rv_cyc); end
    n_cmp++; if (rerr !== 1'b1) begin n_bad++; $display("FAIL to_resp_err got %b want 1", rerr); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL to_resp_data got %h want 0", rdata); end
    n_cmp++; if (req_hi != 18) begin n_bad++; $display("FAIL to_req_core_cycles got %0d want 18", req_hi); end
    n_cmp++; if ({req_core, stall_out} !== 2'b00) begin n_bad++; $display("FAIL to_back_idle got %b want 00", {req_core, stall_out}); end
    bus_data_in = 32'h0;
  endtask

  task automatic test_retry();
    clear_tally();
    issue(2'b01, 32'h0000_02C0, 32'h0, 7'h03);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      grant = (c inside {1, 2, 3, 6, 7, 8});
      l2_valid_in = (c == 8);
      bus_data_in = (c == 8) ? 32'h0BAD_F00D : 32'h0;
    end
    n_cmp++; if (fl_cnt != 1 || fl_cyc != 5) begin n_bad++; $display("FAIL retry_flush got cnt %0d cyc %0d want cnt 1 cyc 5", fl_cnt, fl_cyc); end
    n_cmp++; if (addr_cnt != 2) begin n_bad++; $display("FAIL retry_addr_cycles got %0d want 2", addr_cnt); end
    n_cmp++; if (first_addr !== 32'h2C0 || seen_addr !== 32'h2C0 || seen_op !== 2'b01) begin n_bad++; $display("FAIL retry_addr got %h/%h op %b want 000002c0 twice op 01", first_addr, seen_addr, seen_op); end
    n_cmp++; if (rv_cnt != 1 || rv_cyc != 9) begin n_bad++; $display("FAIL retry_resp_valid got cnt %0d cyc %0d want cnt 1 cyc 9", rv_cnt, rv_cyc); end
    n_cmp++; if (rdata !== 32'h0BAD_F00D || rerr !== 1'b0) begin n_bad++; $display("FAIL retry_resp got %h err %b want 0badf00d err 0", rdata, rerr); end
    n_cmp++; if (req_hi != 8) begin n_bad++; $display("FAIL retry_req_core_cycles got %0d want 8", req_hi); end
    l2_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_tally();
    issue(2'b01, 32'h0000_0500, 32'h0, 7'h03);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      miss_req = 1'b0;
      grant = 1'b1;
    end
    reset = 1'b1;
    l2_valid_in = 1'b1;
    bus_data_in = 32'h0000_0077;
    #1;
    n_cmp++; if ({req_core, stall_out, flush_out, resp_valid} !== 4'b0000) begin n_bad++; $display("FAIL rmid_ctrl got %b want 0000", {req_core, stall_out, flush_out, resp_valid}); end
    n_cmp++; if (bus_operation_out !== 2'b00 || bus_address_out !== 32'h0 || resp_data !== 32'h0) begin n_bad++; $display("FAIL rmid_bus got op %b addr %h rdata %h want zeros", bus_operation_out, bus_address_out, resp_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0; grant = 1'b0; l2_valid_in = 1'b0; bus_data_in = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      sample(c);
    end
    n_cmp++; if (rv_cnt != 0 || req_hi != 0) begin n_bad++; $display("FAIL rmid_no_resp got rv %0d req %0d want 0 0", rv_cnt, req_hi); end
    clear_tally();
    issue(2'b11, 32'h0000_0600, 32'h0, 7'h2F);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      grant = (c <= 2);
    end
    n_cmp++; if (rv_cyc != 3 || seen_addr !== 32'h600) begin n_bad++; $display("FAIL rmid_next_req got cyc %0d addr %h want 3 00000600", rv_cyc, seen_addr); end
  endtask

  task automatic test_op_none();
    clear_tally();
    issue(2'b00, 32'h0000_0700, 32'h0, 7'h03);
    #1;
    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL none_stall got %b want 0", stall_out); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      sample(c);
      grant = 1'b1;
    end
    n_cmp++; if (req_hi != 0 || addr_cnt != 0 || rv_cnt != 0) begin n_bad++; $display("FAIL none_ignored got req %0d addr %0d rv %0d want 0 0 0", req_hi, addr_cnt, rv_cnt); end
    miss_req = 1'b0; grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_tally();
    st_x = 1'b0;
    issue(2'b01, 32'h0000_0840, 32'h0, 7'h03);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      sample(c);
      miss_req = 1'b0;
      if (c == 2) issue(2'b10, 32'h0000_BAD0, 32'h9, 7'h23);
      if (c == 5) begin
        issue(2'b11, 32'h0000_0200, 32'h0, 7'h2F);
        #1 st_x = stall_out;
      end
      grant = (c inside {1, 2, 3, 6, 7});
      l2_valid_in = (c == 3);
      bus_data_in = (c == 3) ? 32'h0000_0011 : 32'h0;
    end
    n_cmp++; if (rv_cnt != 2 || rv_cyc != 8) begin n_bad++; $display("FAIL b2b_resp_valid got cnt %0d last %0d want cnt 2 last 8", rv_cnt, rv_cyc); end
    n_cmp++; if (addr_cnt != 2 || first_addr !== 32'h840) begin n_bad++; $display("FAIL b2b_first got cnt %0d addr %h want 2 00000840", addr_cnt, first_addr); end
    n_cmp++; if (seen_op !== 2'b11 || seen_addr !== 32'h200) begin n_bad++; $display("FAIL b2b_second got %b/%h want 11/00000200", seen_op, seen_addr); end
    n_cmp++; if (st_x !== 1'b1) begin n_bad++; $display("FAIL b2b_stall got %b want 1", st_x); end
    n_cmp++; if (req_hi != 5) begin n_bad++; $display("FAIL b2b_req_core_cycles got %0d want 5", req_hi); end
    l2_valid_in = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; miss_req = 1'b0; miss_op = 2'b00; miss_addr = '0; miss_wdata = '0;
    opcode_in = '0; grant = 1'b0; bus_data_in = '0; cache_hit_in = 1'b0; l2_valid_in = 1'b0;
    st_x = 1'b0;
    clear_tally();
    test_reset();
    test_rd();
    test_rdx();
    test_upgr();
    test_timeout();
    test_retry();
    test_reset_mid();
    test_op_none();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_bus_requester.md
Name: core_bus_requester

Overview:
- Core-side initiator for the shared snooping bus; the bus controller is the arbiter/responder at the other end.
- Takes an L1 miss or upgrade request, raises req_core and waits for grant, then drives one bus transaction.
- Collects the response from the peer cache or L2, returns it to the L1 controller, and stalls the core until done.
- One instance per Processor, between the L1 cache controller and the bus controller.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
TIMEOUT, 16, max cycles in WAIT_RESP before abort (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
miss_req  input  1  L1 request strobe, sampled in IDLE only
miss_op  input  2  bus op: 00 NONE, 01 BUS_RD, 10 BUS_RDX, 11 BUS_UPGR
miss_addr  input  ADDR_W  request address
miss_wdata  input  DATA_W  write data forwarded on BUS_RDX
opcode_in  input  7  RISC-V opcode of the causing instruction
stall_out  output  1  core pipeline stall
resp_valid  output  1  one-cycle response strobe to L1
resp_data  output  DATA_W  returned line word
resp_src  output  1  1 = peer cache supplied, 0 = L2
resp_err  output  1  qualifies resp_valid: timeout abort
req_core  output  1  bus request to arbiter
grant  input  1  bus grant from arbiter
bus_operation_out  output  2  op driven to bus
bus_address_out  output  ADDR_W  address driven to bus
bus_data_out  output  DATA_W  data driven to bus
opcode_out  output  7  opcode driven to bus
flush_out  output  1  one-cycle abort indication to bus controller
bus_data_in  input  DATA_W  response data from bus controller
cache_hit_in  input  1  peer-cache snoop hit, data valid on bus_data_in
l2_valid_in  input  1  L2 response valid on bus_data_in

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0, including bus_operation_out=00, addresses, data, opcode_out and resp_*. Latched request registers cleared, timeout counter 0.
- A reset asserted mid-transaction drops req_core immediately (async); no resp_valid is produced for the killed request.
- FSM states: IDLE, REQ, ADDR, WAIT_RESP, DONE.
- IDLE:
  - If miss_req=1 and miss_op!=00, latch op/addr/wdata/opcode and go to REQ next edge.
  - miss_op=00 with miss_req is ignored.
  - stall_out = miss_req & (miss_op!=00), combinational, so the core stalls in the same cycle.
- REQ: req_core=1. On grant=1, go to ADDR. No timeout applies in REQ; waiting for arbitration is unbounded.
- ADDR (exactly one cycle):
  - Drive bus_operation_out=op, bus_address_out, bus_data_out (wdata for BUS_RDX, else 0) and opcode_out. Outside ADDR, bus_operation_out=00 and the other bus outputs hold 0.
  - BUS_UPGR goes to DONE (no data phase). BUS_RD and BUS_RDX go to WAIT_RESP with the counter cleared.
- WAIT_RESP: counter increments each cycle.
  - cache_hit_in=1: capture bus_data_in, resp_src=1, go to DONE.
  - Else l2_valid_in=1: capture, resp_src=0, go to DONE.
  - Both high in the same cycle: the peer cache wins.
  - grant falls before any response: flush_out=1 for one cycle, go to REQ, retry with the same latched request.
  - counter reaches TIMEOUT-1 with no response: flush_out=1, resp_err=1, go to DONE.
- DONE (one cycle):
  - resp_valid=1. resp_data holds the captured data (0 for UPGR or error). resp_src and resp_err are valid this cycle only.
  - req_core=0. Next state is IDLE.
- req_core stays high continuously from REQ through WAIT_RESP and is low in DONE.
- stall_out=1 in REQ, ADDR, WAIT_RESP and DONE. It drops in IDLE when there is no new request.
- Back-to-back requests: a new request can be latched in the IDLE cycle right after DONE.
- miss_req asserted while not in IDLE is ignored.

Test Plan:
- BUS_RD 0x0000_0040, grant after 3 cycles, l2_valid_in with 0xDEAD_BEEF two cycles after ADDR -> req_core high 6 cycles; bus_operation_out=01 for exactly one cycle; resp_valid with resp_data=0xDEAD_BEEF, resp_src=0.
- BUS_RDX addr 0x80, wdata 0x1234; cache_hit_in and l2_valid_in high together, bus_data_in=0xCAFE -> bus_data_out=0x1234 in ADDR; resp_src=1, resp_data=0xCAFE.
- BUS_UPGR addr 0x100 with immediate grant -> sequence IDLE,REQ,ADDR,DONE; resp_valid in the 4th cycle; resp_data=0; no WAIT_RESP.
- BUS_RD with no response, TIMEOUT=16 -> flush_out pulse after 16 WAIT_RESP cycles; resp_valid=1, resp_err=1; return to IDLE.
- grant dropped in WAIT_RESP cycle 2, then re-granted -> flush_out single pulse; ADDR repeated with identical address and op; normal completion follows.
- reset asserted during WAIT_RESP -> all outputs 0 asynchronously; no resp_valid after release; next miss_req processed normally.
